// File: rtl/msg_framer_tx.sv
// Transmit-side message framer: buffers one response payload, then emits
// len, seq, payload, crc16-ccitt (hi, lo) and the sync byte toward the UART.
module msg_framer_tx #(
  parameter int unsigned MAX_PAYLOAD = 59,
  parameter logic [7:0]  SYNC_BYTE   = 8'h7e,
  parameter logic [3:0]  SEQ_HI      = 4'h1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic [3:0] ack_seq,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int            CW       = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PAYLOAD - 1);

  typedef enum logic [2:0] {
    COLLECT, LEN, SEQ, PAY, CRCH, CRCL, SYNC
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] count, rd_idx;
  logic [7:0]    buffer [MAX_PAYLOAD];
  logic [15:0]   crc, crc_upd;
  logic [3:0]    seq_lo;
  logic          in_fire, out_fire, last_take, out_valid_d;
  logic [7:0]    out_data_d;

  // Byte-wise crc16-ccitt update, identical to the receive-side checker.
  function automatic logic [15:0] crc16ccitt(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] d;
    d = b ^ c[7:0];
    d = d ^ (d << 4);
    return {d, c[15:8]} ^ {12'h000, d[7:4]} ^ {5'b00000, d, 3'b000};
  endfunction

  assign in_ready  = (state == COLLECT);
  assign in_fire   = in_valid && in_ready;
  assign last_take = in_fire && (in_last || count == LAST_IDX);
  assign out_fire  = out_valid && out_ready;
  assign crc_upd   = crc16ccitt(crc, out_data);

  // Next-state and next output byte; output only advances on a handshake.
  always_comb begin
    state_d     = state;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    unique case (state)
      COLLECT: if (last_take) begin
        state_d     = LEN;
        out_data_d  = 8'(count) + 8'd6;
        out_valid_d = 1'b1;
      end
      LEN: if (out_fire) begin
        state_d    = SEQ;
        out_data_d = {SEQ_HI, seq_lo};
      end
      SEQ: if (out_fire) begin
        state_d    = PAY;
        out_data_d = buffer[0];
      end
      PAY: if (out_fire) begin
        if (rd_idx == count) begin
          state_d    = CRCH;
          out_data_d = crc_upd[15:8];
        end else begin
          out_data_d = buffer[rd_idx];
        end
      end
      CRCH: if (out_fire) begin
        state_d    = CRCL;
        out_data_d = crc[7:0];
      end
      CRCL: if (out_fire) begin
        state_d    = SYNC;
        out_data_d = SYNC_BYTE;
      end
      SYNC: if (out_fire) begin
        state_d     = COLLECT;
        out_valid_d = 1'b0;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      count     <= '0;
      rd_idx    <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      overflow  <= in_fire && (count == LAST_IDX);
      if (in_fire)
        count <= count + CW'(1);
      else if (state == SYNC && out_fire)
        count <= '0;
      if (in_fire)
        busy <= 1'b1;
      else if (state == SYNC && out_fire)
        busy <= 1'b0;
      if (state == SEQ && out_fire)
        rd_idx <= CW'(1);
      else if (state == PAY && out_fire)
        rd_idx <= rd_idx + CW'(1);
    end
  end

  // Payload store, crc accumulator and sampled seq nibble carry no reset.
  always_ff @(posedge clk) begin
    if (in_fire)
      buffer[count] <= in_data;
    if (last_take)
      seq_lo <= ack_seq;
    if (last_take)
      crc <= 16'hffff;
    else if (out_fire && (state == LEN || state == SEQ || state == PAY))
      crc <= crc_upd;
  end

endmodule
